// File: rtl/register_bank_scoreboard.sv
// register_bank_scoreboard
// 32-entry MIPS general-purpose register bank with a per-register busy
// scoreboard. Register 0 is hardwired to zero and can never be marked busy.
// Writes become visible on Registers_Out the cycle after the clock edge; there
// is no write-through bypass, so Stall is likewise released one cycle after the
// writeback edge.
module register_bank_scoreboard #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] GP_INIT    = 32'h1000_8000,
  parameter logic [DATA_WIDTH-1:0] SP_INIT    = 32'h7FFF_EFFC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     Reg_Write,
  input  logic [4:0]               Write_Register,
  input  logic [DATA_WIDTH-1:0]    Write_Data,
  input  logic                     Issue_Valid,
  input  logic [4:0]               Issue_Register,
  input  logic [4:0]               Rs_Sel,
  input  logic [4:0]               Rt_Sel,
  output logic [32*DATA_WIDTH-1:0] Registers_Out,
  output logic [31:0]              Busy_Out,
  output logic                     Stall
);

  localparam logic [4:0] GP_IDX = 5'd28;
  localparam logic [4:0] SP_IDX = 5'd29;

  logic [DATA_WIDTH-1:0] regs_q [32];
  logic [DATA_WIDTH-1:0] regs_d [32];
  logic [31:0]           busy_q;
  logic [31:0]           busy_d;
  logic                  write_en_s;
  logic                  issue_en_s;

  // Reset value of register idx: $gp and $sp get their ABI start values.
  function automatic logic [DATA_WIDTH-1:0] reset_value(input logic [4:0] idx);
    logic [DATA_WIDTH-1:0] val;
    case (idx)
      GP_IDX:  val = GP_INIT;
      SP_IDX:  val = SP_INIT;
      default: val = {DATA_WIDTH{1'b0}};
    endcase
    return val;
  endfunction

  // Qualify writeback and issue: any access that targets register 0 is ignored.
  always_comb begin
    write_en_s = 1'b0;
    issue_en_s = 1'b0;
    if (Reg_Write && (Write_Register != 5'd0)) begin
      write_en_s = 1'b1;
    end else begin
      write_en_s = 1'b0;
    end
    if (Issue_Valid && (Issue_Register != 5'd0)) begin
      issue_en_s = 1'b1;
    end else begin
      issue_en_s = 1'b0;
    end
  end

  // Next-state for the bank and scoreboard; set is applied after clear so a
  // younger issue to the same register wins over the older writeback.
  always_comb begin
    for (int k = 0; k < 32; k++) begin
      regs_d[k] = regs_q[k];
    end
    busy_d = busy_q;
    if (write_en_s) begin
      regs_d[Write_Register] = Write_Data;
      busy_d[Write_Register] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (issue_en_s) begin
      busy_d[Issue_Register] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    regs_d[0] = {DATA_WIDTH{1'b0}};
    busy_d[0] = 1'b0;
  end

  // State update; synchronous reset overrides any concurrent write or issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 32; k++) begin
        regs_q[k] <= reset_value(5'(k));
      end
      busy_q <= 32'h0000_0000;
    end else begin
      for (int k = 0; k < 32; k++) begin
        regs_q[k] <= regs_d[k];
      end
      busy_q <= busy_d;
    end
  end

  // Flatten the bank for the read-port multiplexers; slice k is register k.
  always_comb begin
    Registers_Out = {(32*DATA_WIDTH){1'b0}};
    for (int k = 0; k < 32; k++) begin
      Registers_Out[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
    end
  end

  // Hazard detect from the registered scoreboard only (no bypass path).
  always_comb begin
    Busy_Out = busy_q;
    Stall    = busy_q[Rs_Sel] | busy_q[Rt_Sel];
  end

endmodule
